// File: rtl/hp_pkg.sv
// Shared types and defaults for the player HP controller.
// Holds the FSM state enum, HP width and parameter defaults.
package hp_pkg;

  localparam int HP_W             = 16;
  localparam int DEF_MAX_HP       = 20;
  localparam int DEF_IFRAME_TICKS = 60;
  localparam int DEF_DRAIN_STEP   = 1;

  typedef enum logic [1:0] {
    ST_ALIVE,
    ST_INVULN,
    ST_DYING,
    ST_DEAD
  } hp_state_e;

  function automatic logic [HP_W-1:0] sat_sub(
    input logic [HP_W-1:0] a,
    input logic [HP_W-1:0] b
  );
    return (a > b) ? (a - b) : '0;
  endfunction

endpackage

// File: rtl/hp_drain_anim.sv
// Display HP ramp: snaps up to the target, drains down by at
// most DRAIN_STEP per frame tick without undershooting it.
module hp_drain_anim
  import hp_pkg::*;
#(
  parameter int DRAIN_STEP = DEF_DRAIN_STEP,
  parameter int RST_VAL    = DEF_MAX_HP
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_tick,
  input  logic [HP_W-1:0] i_target,
  input  logic            i_restart,
  output logic [HP_W-1:0] o_disp
);

  localparam logic [HP_W-1:0] STEP = HP_W'(DRAIN_STEP);
  localparam logic [HP_W-1:0] RSTV = HP_W'(RST_VAL);

  logic [HP_W-1:0] r_disp;
  logic [HP_W-1:0] w_gap;
  logic [HP_W-1:0] w_step;
  logic [HP_W-1:0] w_disp_nxt;

  always_comb begin
    w_gap      = r_disp - i_target;
    w_step     = (w_gap < STEP) ? w_gap : STEP;
    w_disp_nxt = r_disp;
    if (r_disp < i_target) begin
      w_disp_nxt = i_target;
    end else if ((r_disp > i_target) && i_tick) begin
      w_disp_nxt = r_disp - w_step;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_disp <= RSTV;
    end else if (i_restart) begin
      r_disp <= RSTV;
    end else begin
      r_disp <= w_disp_nxt;
    end
  end

  assign o_disp = r_disp;

endmodule

// File: rtl/hp_controller.sv
// Player HP owner: damage handshake, heal, invulnerability
// frames, death detection and the animated display value.
module hp_controller
  import hp_pkg::*;
#(
  parameter int MAX_HP       = DEF_MAX_HP,
  parameter int IFRAME_TICKS = DEF_IFRAME_TICKS,
  parameter int DRAIN_STEP   = DEF_DRAIN_STEP
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_tick,
  input  logic        i_restart,
  input  logic        i_dmg_valid,
  input  logic [15:0] i_dmg_amount,
  output logic        o_dmg_ready,
  input  logic        i_heal_valid,
  input  logic [15:0] i_heal_amount,
  output logic [15:0] o_total_hp,
  output logic [15:0] o_remain_hp,
  output logic [15:0] o_disp_hp,
  output logic        o_invuln,
  output logic        o_dead
);

  localparam int CNT_W = $clog2(IFRAME_TICKS + 1);
  localparam logic [HP_W-1:0]  MAX_V = HP_W'(MAX_HP);
  localparam logic [CNT_W-1:0] IF_V  = CNT_W'(IFRAME_TICKS);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  hp_state_e        r_state;
  hp_state_e        w_state_nxt;
  logic [HP_W-1:0]  r_remain;
  logic [HP_W-1:0]  w_remain_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_invuln;
  logic             r_dead;
  logic             w_accept;
  logic             w_hit;
  logic             w_heal_en;
  logic [HP_W:0]    w_heal_sum;
  logic [HP_W-1:0]  w_healed;
  logic [HP_W-1:0]  w_disp;

  assign o_dmg_ready = (r_state == ST_ALIVE) & ~i_restart;
  assign w_accept    = i_dmg_valid & o_dmg_ready;
  assign w_hit       = w_accept & (i_dmg_amount != '0);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_heal_en   = i_heal_valid &
                  ((r_state == ST_ALIVE) | (r_state == ST_INVULN));
    w_heal_sum  = {1'b0, r_remain} + {1'b0, i_heal_amount};
    w_healed    = r_remain;
    if (w_heal_en) begin
      w_healed = (w_heal_sum > {1'b0, MAX_V}) ?
                 MAX_V : w_heal_sum[HP_W-1:0];
    end
    // Heal is clamped first, then damage saturates, in one update
    w_remain_nxt = w_accept ?
                   sat_sub(w_healed, i_dmg_amount) : w_healed;
    unique case (r_state)
      ST_ALIVE: begin
        if (w_hit) begin
          if (w_remain_nxt == '0) begin
            w_state_nxt = ST_DYING;
          end else begin
            w_state_nxt = ST_INVULN;
            w_cnt_nxt   = IF_V;
          end
        end
      end
      ST_INVULN: begin
        if (i_tick) begin
          w_cnt_nxt = r_cnt - ONE;
          if (r_cnt == ONE) w_state_nxt = ST_ALIVE;
        end
      end
      ST_DYING: begin
        if (w_disp == '0) w_state_nxt = ST_DEAD;
      end
      ST_DEAD: begin
        w_state_nxt = ST_DEAD;
      end
      default: begin
        w_state_nxt = ST_ALIVE;
      end
    endcase
    if (i_restart) begin
      w_state_nxt  = ST_ALIVE;
      w_remain_nxt = MAX_V;
      w_cnt_nxt    = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= ST_ALIVE;
      r_remain <= MAX_V;
      r_cnt    <= '0;
      r_invuln <= 1'b0;
      r_dead   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_remain <= w_remain_nxt;
      r_cnt    <= w_cnt_nxt;
      r_invuln <= (w_state_nxt == ST_INVULN);
      r_dead   <= (w_state_nxt == ST_DEAD);
    end
  end

  hp_drain_anim #(
    .DRAIN_STEP (DRAIN_STEP),
    .RST_VAL    (MAX_HP)
  ) u_drain (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_tick    (i_tick),
    .i_target  (r_remain),
    .i_restart (i_restart),
    .o_disp    (w_disp)
  );

  assign o_total_hp  = MAX_V;
  assign o_remain_hp = r_remain;
  assign o_disp_hp   = w_disp;
  assign o_invuln    = r_invuln;
  assign o_dead      = r_dead;

endmodule

// File: doc/hp_controller.md
Name: hp_controller

Overview:
- Owns the player's HP state. Accepts damage requests through a valid/ready handshake from the collision logic and heal pulses from the item logic.
- Enforces invulnerability frames and detects death.
- Produces the total and remaining HP values consumed by the HP bar geometry block.
- Also produces a frame-animated display HP that drains toward the true value, so the bar shrinks smoothly.

Parameters:
- MAX_HP, 20: full HP. Legal range 1..65535. Also the reset and restart value.
- IFRAME_TICKS, 60: frame ticks of invulnerability after a non-lethal hit. Must be >= 1.
- DRAIN_STEP, 1: maximum HP units the display value drops per frame tick. Must be >= 1.

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  asynchronous active-low reset
- i_tick  in  1  one-cycle frame strobe (60 Hz)
- i_restart  in  1  one-cycle pulse; returns the block to its reset state
- i_dmg_valid  in  1  damage request; held until accepted
- i_dmg_amount  in  16  damage value, sampled when accepted
- o_dmg_ready  out  1  high only in ALIVE
- i_heal_valid  in  1  one-cycle heal pulse (no ready)
- i_heal_amount  in  16  heal value
- o_total_hp  out  16  constant MAX_HP
- o_remain_hp  out  16  true HP, registered
- o_disp_hp  out  16  animated HP, registered; feeds the bar
- o_invuln  out  1  high in INVULN
- o_dead  out  1  high in DEAD

Behaviour:
- Reset (async, i_rst_n=0):
  - state=ALIVE, remain=disp=MAX_HP.
  - iframe counter=0, o_invuln=0, o_dead=0, o_dmg_ready=1.
- States and transitions:
  - ALIVE → INVULN on accepted nonzero damage with a result > 0.
  - ALIVE → DYING on accepted damage with a result == 0.
  - INVULN → ALIVE on the i_tick that decrements the counter from 1 to 0.
  - DYING → DEAD on the first cycle where disp == 0.
  - DEAD holds until i_restart.
- Damage handshake:
  - Transfer occurs on an edge where i_dmg_valid & o_dmg_ready.
  - remain <= remain - amount, saturating at 0.
  - An accepted amount of 0 changes nothing and does not enter INVULN.
  - A valid held during INVULN is not dropped. It is accepted on the first ALIVE cycle.
- Heal:
  - Honoured in ALIVE and INVULN; ignored in DYING and DEAD.
  - remain <= min(remain + amount, MAX_HP), computed in 17 bits.
- Heal and accepted damage in the same cycle:
  - Apply the clamped heal first, then saturating damage, in one update.
  - State decisions use the final value.
- Iframe counter:
  - Loaded with IFRAME_TICKS on entry to INVULN.
  - Decrements only on i_tick.
  - A tick on the same edge as the hit does not decrement.
- Display drain, evaluated every cycle:
  - If disp < remain, disp <= remain on the next edge (heals appear instantly).
  - If disp > remain and i_tick, disp <= disp - min(DRAIN_STEP, disp - remain).
  - disp never undershoots remain.
- o_total_hp: tied to MAX_HP; no logic.
- Latency: o_remain_hp, o_invuln and o_dead update on the edge after acceptance.
- Restart:
  - i_restart has priority over damage and heal in any state.
  - It restores reset values on the next edge. A damage valid present that cycle is not accepted (o_dmg_ready is forced 0 during the restart cycle).
- Outputs are glitch-free registers, except o_dmg_ready = (state==ALIVE) & ~i_restart.

Decomposition:
- Shared package hp_pkg holds:
  - the state enum (ALIVE, INVULN, DYING, DEAD);
  - the HP width constant (16);
  - the default constants for MAX_HP, IFRAME_TICKS and DRAIN_STEP.
- One sub-module, hp_drain_anim, implements the display ramp.
  - Inputs: clk, rst_n, tick, target, restart.
  - Output: disp.
  - Parameter: DRAIN_STEP.
- The FSM, handshake, saturation arithmetic and iframe counter stay in hp_controller.

Test Plan:
- Reset, then hold dmg_valid with amount 5 in ALIVE → accepted in 1 cycle; remain=15, o_invuln=1, o_dmg_ready=0; disp reaches 15 after 5 ticks (DRAIN_STEP=1).
- Hold damage 3 during INVULN with IFRAME_TICKS=60 → not accepted for 60 ticks; accepted on the first ALIVE cycle; remain drops by 3.
- remain=4, damage 9 → remain=0, state DYING, o_dead=0 until disp drains to 0 (4 ticks), then o_dead=1; dmg_valid is never accepted afterwards.
- remain=18 plus heal 7 → remain=20 (clamped); remain=10 with heal 5 and damage 12 in the same cycle → remain=3, INVULN; disp snaps up on heal, ramps down on damage.
- In DEAD, pulse i_restart with dmg_valid high → next edge remain=disp=20, ALIVE, o_dead=0, no damage taken; async reset asserted mid-INVULN → immediate reset values.
- Damage 0 accepted → no state change, o_invuln stays 0; damage 65535 from full → saturates to 0 with no wrap-around.
